// File: rtl/mini_risc_control_fsm.sv
// Multi-cycle control unit for the KGP-miniRISC core: sequences data_path control
// through fetch/decode/execute/memory/write-back from the decoded opcode and func.
module mini_risc_control_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   output logic [1:0] reg_write,
   output logic       imm_mux_ctrl,
   output logic       alu_mux_ctrl,
   output logic [3:0] alu_op,
   output logic       dmem_enable,
   output logic       dmem_write_enable,
   output logic [1:0] reg_write_mux_ctrl,
   output logic [4:0] br_op,
   output logic [2:0] state_out,
   output logic       instr_done,
   output logic       illegal
);

   // state  | meaning
   // FETCH  | instruction fetch, all controls idle
   // DECODE | opcode/func examined, latched on exit if legal
   // EXEC   | ALU operation / branch resolution
   // MEM    | data-memory access (lw, sw)
   // WB     | register-file write-back
   // TRAP   | undefined instruction, held until reset
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CLS_R   = 3'd0,
      CLS_IMM = 3'd1,
      CLS_LW  = 3'd2,
      CLS_SW  = 3'd3,
      CLS_BR  = 3'd4,
      CLS_BL  = 3'd5
   } cls_t;

   typedef struct packed {
      logic [1:0] reg_write;
      logic       imm_mux;
      logic       alu_mux;
      logic [3:0] alu_op;
      logic       dmem_en;
      logic       dmem_we;
      logic [1:0] wb_mux;
      logic [4:0] br_op;
      logic       done;
   } ctrl_t;

   state_t state;
   cls_t   cls;
   ctrl_t  ctrl;

   ctrl_t  dec_ctrl;
   cls_t   dec_cls;
   logic   dec_legal;

   // Decode yields the control word seen in EXEC; it is only consumed on the DECODE exit edge.
   always_comb begin
      dec_ctrl  = '0;
      dec_cls   = CLS_R;
      dec_legal = 1'b1;
      case (opcode)
         6'd0: begin
            dec_cls         = CLS_R;
            dec_ctrl.wb_mux = 2'b10;
            if (func <= 6'd9) begin
               dec_ctrl.alu_op = func[3:0];
            end else begin
               dec_legal = 1'b0;
            end
         end
         6'd1, 6'd2: begin
            dec_cls          = CLS_IMM;
            dec_ctrl.alu_mux = 1'b1;
            dec_ctrl.alu_op  = (opcode == 6'd2) ? 4'd1 : 4'd0;
            dec_ctrl.wb_mux  = 2'b10;
         end
         6'd3: begin
            dec_cls          = CLS_LW;
            dec_ctrl.imm_mux = 1'b1;
            dec_ctrl.alu_mux = 1'b1;
            dec_ctrl.wb_mux  = 2'b01;
         end
         6'd4: begin
            dec_cls          = CLS_SW;
            dec_ctrl.imm_mux = 1'b1;
            dec_ctrl.alu_mux = 1'b1;
         end
         6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11: begin
            dec_cls        = (opcode == 6'd9) ? CLS_BL : CLS_BR;
            dec_ctrl.br_op = opcode[4:0] - 5'd4;
            dec_ctrl.done  = (opcode != 6'd9);
         end
         default: dec_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FETCH;
         cls     <= CLS_R;
         ctrl    <= '0;
         illegal <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               state <= DECODE;
               ctrl  <= '0;
            end
            DECODE: begin
               if (dec_legal) begin
                  state <= EXEC;
                  cls   <= dec_cls;
                  ctrl  <= dec_ctrl;
               end else begin
                  state   <= TRAP;
                  illegal <= 1'b1;
                  ctrl    <= '0;
               end
            end
            EXEC: begin
               case (cls)
                  CLS_LW, CLS_SW: begin
                     state        <= MEM;
                     ctrl.dmem_en <= 1'b1;
                     ctrl.dmem_we <= (cls == CLS_SW);
                     ctrl.done    <= (cls == CLS_SW);
                  end
                  CLS_BR: begin
                     state <= FETCH;
                     ctrl  <= '0;
                  end
                  default: begin
                     state          <= WB;
                     ctrl.br_op     <= '0;
                     ctrl.reg_write <= (cls == CLS_BL) ? 2'b11 : 2'b01;
                     ctrl.done      <= 1'b1;
                  end
               endcase
            end
            MEM: begin
               if (cls == CLS_LW) begin
                  state          <= WB;
                  ctrl.dmem_en   <= 1'b0;
                  ctrl.dmem_we   <= 1'b0;
                  ctrl.reg_write <= 2'b10;
                  ctrl.done      <= 1'b1;
               end else begin
                  state <= FETCH;
                  ctrl  <= '0;
               end
            end
            WB: begin
               state <= FETCH;
               ctrl  <= '0;
            end
            TRAP: begin
               state   <= TRAP;
               ctrl    <= '0;
               illegal <= 1'b1;
            end
            default: begin
               state <= FETCH;
               ctrl  <= '0;
            end
         endcase
      end
   end

   assign reg_write          = ctrl.reg_write;
   assign imm_mux_ctrl       = ctrl.imm_mux;
   assign alu_mux_ctrl       = ctrl.alu_mux;
   assign alu_op             = ctrl.alu_op;
   assign dmem_enable        = ctrl.dmem_en;
   assign dmem_write_enable  = ctrl.dmem_we;
   assign reg_write_mux_ctrl = ctrl.wb_mux;
   assign br_op              = ctrl.br_op;
   assign instr_done         = ctrl.done;
   assign state_out          = state;

endmodule

// File: tb/tb_mini_risc_control_fsm.sv
// Scoreboard bench for mini_risc_control_fsm: per-cycle expected output snapshots are
// queued when an instruction is driven and popped against the DUT each cycle.
module tb_mini_risc_control_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] func = '0;
   logic [1:0] reg_write;
   logic       imm_mux_ctrl;
   logic       alu_mux_ctrl;
   logic [3:0] alu_op;
   logic       dmem_enable;
   logic       dmem_write_enable;
   logic [1:0] reg_write_mux_ctrl;
   logic [4:0] br_op;
   logic [2:0] state_out;
   logic       instr_done;
   logic       illegal;

   mini_risc_control_fsm dut (
      .clk                (clk),
      .rst                (rst),
      .opcode             (opcode),
      .func               (func),
      .reg_write          (reg_write),
      .imm_mux_ctrl       (imm_mux_ctrl),
      .alu_mux_ctrl       (alu_mux_ctrl),
      .alu_op             (alu_op),
      .dmem_enable        (dmem_enable),
      .dmem_write_enable  (dmem_write_enable),
      .reg_write_mux_ctrl (reg_write_mux_ctrl),
      .br_op              (br_op),
      .state_out          (state_out),
      .instr_done         (instr_done),
      .illegal            (illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] state;
      logic [1:0] rw;
      logic       imm;
      logic       amux;
      logic [3:0] aop;
      logic       den;
      logic       dwe;
      logic [1:0] wbm;
      logic [4:0] br;
      logic       done;
      logic       ill;
   } snap_t;

   snap_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   function automatic snap_t observe();
      snap_t s;
      s.state = state_out;
      s.rw    = reg_write;
      s.imm   = imm_mux_ctrl;
      s.amux  = alu_mux_ctrl;
      s.aop   = alu_op;
      s.den   = dmem_enable;
      s.dwe   = dmem_write_enable;
      s.wbm   = reg_write_mux_ctrl;
      s.br    = br_op;
      s.done  = instr_done;
      s.ill   = illegal;
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference sequence for one instruction, starting with its FETCH cycle.
   task automatic push_expected(input logic [5:0] op, input logic [5:0] fn);
      snap_t s;
      logic  bad;
      s = '0;
      exp_q.push_back(s);
      s.state = 3'd1;
      exp_q.push_back(s);
      bad = (op > 6'd11) || (op == 6'd0 && fn > 6'd9);
      if (bad) begin
         s.state = 3'd7;
         s.ill   = 1'b1;
         repeat (12) exp_q.push_back(s);
         return;
      end
      s.state = 3'd2;
      case (op)
         6'd0: begin s.aop = fn[3:0]; s.wbm = 2'b10; end
         6'd1: begin s.amux = 1'b1; s.aop = 4'd0; s.wbm = 2'b10; end
         6'd2: begin s.amux = 1'b1; s.aop = 4'd1; s.wbm = 2'b10; end
         6'd3: begin s.imm = 1'b1; s.amux = 1'b1; s.wbm = 2'b01; end
         6'd4: begin s.imm = 1'b1; s.amux = 1'b1; end
         default: s.br = 5'(op - 6'd4);
      endcase
      if (op >= 6'd5 && op != 6'd9) begin
         s.done = 1'b1;
         exp_q.push_back(s);
      end else if (op == 6'd9) begin
         exp_q.push_back(s);
         s.state = 3'd4; s.br = '0; s.rw = 2'b11; s.done = 1'b1;
         exp_q.push_back(s);
      end else if (op == 6'd3) begin
         exp_q.push_back(s);
         s.state = 3'd3; s.den = 1'b1;
         exp_q.push_back(s);
         s.state = 3'd4; s.den = 1'b0; s.rw = 2'b10; s.done = 1'b1;
         exp_q.push_back(s);
      end else if (op == 6'd4) begin
         exp_q.push_back(s);
         s.state = 3'd3; s.den = 1'b1; s.dwe = 1'b1; s.done = 1'b1;
         exp_q.push_back(s);
      end else begin
         exp_q.push_back(s);
         s.state = 3'd4; s.rw = 2'b01; s.done = 1'b1;
         exp_q.push_back(s);
      end
   endtask

   // Entered at a falling edge with the DUT in FETCH; returns the same way.
   // abort_at > 0 asserts rst after that many compared cycles.
   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input int abort_at);
      snap_t e;
      int    n;
      push_expected(op, fn);
      opcode = op;
      func   = fn;
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("%s.c%0d", name, n), 32'(observe()), 32'(e));
         n++;
         if (e.state >= 3'd2) begin
            opcode = 6'($urandom);
            func   = 6'($urandom);
         end
         if (n == abort_at) begin
            exp_q.delete();
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.rst", name), 32'(observe()), 32'(snap_t'('0)));
            rst = 1'b0;
            return;
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset", 32'(observe()), 32'(snap_t'('0)));
      rst = 1'b0;

      run_instr("xor",   6'd0, 6'd3, 0);
      run_instr("addi",  6'd1, 6'd0, 0);
      run_instr("compi", 6'd2, 6'd0, 0);
      run_instr("add",   6'd0, 6'd0, 0);
      run_instr("shrav", 6'd0, 6'd9, 0);
      run_instr("sw",    6'd4, 6'd0, 0);
      run_instr("lw",    6'd3, 6'd0, 0);
      run_instr("bz",    6'd7, 6'd0, 0);
      run_instr("bl",    6'd9, 6'd0, 0);
      run_instr("br",    6'd5, 6'd0, 0);
      run_instr("bncy",  6'd11, 6'd0, 0);

      run_instr("ill_func12", 6'd0,  6'd12, 14);
      run_instr("ill_op40",   6'd40, 6'd0,  14);
      run_instr("ill_func10", 6'd0,  6'd10, 3);
      run_instr("ill_op12",   6'd12, 6'd5,  14);
      run_instr("post_trap",  6'd1,  6'd0,  0);

      run_instr("sw_rst", 6'd4, 6'd0, 4);
      run_instr("lw_rst", 6'd3, 6'd0, 4);
      run_instr("after_rst", 6'd0, 6'd5, 0);

      for (int i = 0; i < 30; i++) begin
         logic [5:0] rop, rfn;
         rop = 6'($urandom_range(0, 11));
         rfn = 6'($urandom_range(0, 9));
         run_instr($sformatf("rnd%0d", i), rop, rfn, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mini_risc_control_fsm.md
# mini_risc_control_fsm

Multi-cycle control unit for the KGP-miniRISC core. It takes the `opcode_out`/`func_out` fields reported by `data_path` and sequences every control input of `data_path` through the phases fetch, decode, execute, memory and write-back. It replaces hand-driven control stimulus, so `data_path` plus this block form a self-running processor.

## Interface
- No parameters. All encodings are fixed by the ISA and listed under Operation.
- `clk` input 1: single system clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 6: instruction opcode from `data_path.opcode_out`.
- `func` input 6: function field from `data_path.func_out`.
- `reg_write` output 2: 00 none, 01 write rs, 10 write rt, 11 write $31 (link).
- `imm_mux_ctrl` output 1: 0 selects the ALU-immediate field, 1 selects the load/store offset field.
- `alu_mux_ctrl` output 1: 0 selects register rt as ALU operand B, 1 selects the immediate.
- `alu_op` output 4: ALU function.
- `dmem_enable` output 1: data-memory enable.
- `dmem_write_enable` output 1: data-memory write strobe.
- `reg_write_mux_ctrl` output 2: 00 PC+4, 01 dmem read data, 10 ALU result.
- `br_op` output 5: 0 none, 1 br, 2 bltz, 3 bz, 4 bnz, 5 bl, 6 bcy, 7 bncy.
- `state_out` output 3: current FSM state, for debug.
- `instr_done` output 1: one-cycle pulse in the last cycle of every instruction.
- `illegal` output 1: sticky flag, set when an undefined opcode or func is decoded.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Opcode map:
  - 0 = R-type. `alu_op`=func[3:0] for func 0–9 (0 add, 1 comp, 2 and, 3 xor, 4 shll, 5 shrl, 6 shllv, 7 shrlv, 8 shra, 9 shrav). Any other func is illegal.
  - 1 = addi (alu_op 0).
  - 2 = compi (alu_op 1).
  - 3 = lw.
  - 4 = sw.
  - 5–11 = branches, br_op values 1–7 in that order.
  - Any other opcode is illegal.
- `opcode` and `func` are registered on the DECODE→EXEC edge. Changes on the inputs after that edge are ignored until the next DECODE.
- Transitions:
  - FETCH→DECODE always.
  - DECODE→EXEC if the instruction is legal; otherwise DECODE→TRAP.
  - EXEC→WB for R-type, addi, compi and bl.
  - EXEC→MEM for lw and sw.
  - EXEC→FETCH for all branches except bl.
  - MEM→WB for lw; MEM→FETCH for sw.
  - WB→FETCH always.
  - TRAP holds until `rst`.
- Control is held constant from EXEC until the instruction ends; the datapath timing depends on this. Values per class:
  - R-type: alu_mux 0, wb mux 10, reg_write 01.
  - addi/compi: alu_mux 1, imm_mux 0, wb mux 10, reg_write 01.
  - lw: imm_mux 1, alu_mux 1, alu_op 0, wb mux 01, reg_write 10.
  - sw: imm_mux 1, alu_mux 1, alu_op 0, reg_write 00.
  - bl: wb mux 00, reg_write 11.
- Strobe windows:
  - `reg_write` is non-zero only in WB.
  - `dmem_enable` is high only in MEM.
  - `dmem_write_enable` is high only in MEM, and only for sw.
  - `br_op` is non-zero only in EXEC.
- In FETCH, DECODE and TRAP, every control output is 0.

## Timing
- Reset:
  - While `rst` is high at a rising edge, the next state is FETCH.
  - All outputs are 0 and `illegal` is cleared.
  - Reset wins over any in-flight state, including TRAP. No partial write survives, because strobes are registered from the state.
- Latency in cycles, counted from FETCH:
  - branch (not bl): 3.
  - R-type, immediate, sw, bl: 4.
  - lw: 5. The dmem read is issued in MEM and the registered read data is valid in WB.
- Outputs are Moore, decoded from the state and the registered instruction. No combinational path exists from `opcode`/`func` to any output.
- `instr_done` is high in the final state of each instruction: EXEC for branches other than bl, MEM for sw, WB otherwise.
- `illegal` rises in the first TRAP cycle and stays high until reset.

## Test plan
- **R-type xor:** after reset, opcode=0, func=3.
  - `state_out` goes 0,1,2,4,0.
  - In EXEC and WB, `alu_op`=3 and `reg_write_mux_ctrl`=10.
  - `reg_write`=01 only in WB; `instr_done` high in WB.
- **addi:** opcode=1.
  - `alu_mux_ctrl`=1 and `alu_op`=0 from EXEC through WB.
  - `reg_write`=01 for exactly one cycle; total 4 cycles.
- **sw then lw:**
  - sw (opcode 4): `dmem_enable`=`dmem_write_enable`=1 for exactly one cycle (MEM), `reg_write` never set, 4 cycles.
  - lw (opcode 3): `dmem_enable`=1 in MEM with write enable 0, then `reg_write`=10 with wb mux 01 in WB, 5 cycles.
- **Branches:**
  - bz (opcode 7): `br_op`=3 only in EXEC, 3 cycles.
  - bl (opcode 9): `br_op`=5 in EXEC, then `reg_write`=11 with wb mux 00 in WB.
- **Illegal instruction:** opcode=0 with func=12, or opcode=40.
  - DECODE→TRAP; `illegal`=1; all controls 0 for 10+ cycles.
  - `rst` pulse clears `illegal` and returns to FETCH.
- **Reset mid-instruction, and decode latching:**
  - Assert `rst` in MEM of sw. On the next edge `dmem_write_enable`=0 and `state_out`=0.
  - Change `opcode` during EXEC. The outputs do not change.
